// File: rtl/alu_cmd_ctrl.sv
// Byte-stream command controller for the system ALU.
// Parses CC/DD frames, fires the ALU, returns the result as two TX bytes.
module alu_cmd_ctrl #(
  parameter int DW = 8,
  parameter int ALU_TIMEOUT = 16,
  parameter logic [DW-1:0] CMD_ALU_OP = DW'(8'hCC),
  parameter logic [DW-1:0] CMD_ALU_NOP = DW'(8'hDD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   rxData,
  input  logic            rxValid,
  input  logic [2*DW-1:0] aluOut,
  input  logic            aluOutValid,
  input  logic            txReady,
  output logic [DW-1:0]   opA,
  output logic [DW-1:0]   opB,
  output logic [3:0]      aluFun,
  output logic            aluEn,
  output logic [DW-1:0]   txData,
  output logic            txValid,
  output logic            busy,
  output logic            cmdErr
);

  localparam int CW = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(ALU_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GET_A = 3'd1;
  localparam logic [2:0] S_GET_B = 3'd2;
  localparam logic [2:0] S_GET_F = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_TX_LO = 3'd6;
  localparam logic [2:0] S_TX_HI = 3'd7;

  logic [2:0]      state_q, state_d;
  logic [DW-1:0]   opa_q, opa_d;
  logic [DW-1:0]   opb_q, opb_d;
  logic [3:0]      fun_q, fun_d;
  logic [2*DW-1:0] res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  // Next-state, register-load and error-pulse decision
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    fun_d   = fun_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rxValid) begin
          if (rxData == CMD_ALU_OP) begin
            state_d = S_GET_A;
          end else if (rxData == CMD_ALU_NOP) begin
            state_d = S_GET_F;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_GET_A: begin
        if (rxValid) begin
          opa_d   = rxData;
          state_d = S_GET_B;
        end
      end
      S_GET_B: begin
        if (rxValid) begin
          opb_d   = rxData;
          state_d = S_GET_F;
        end
      end
      S_GET_F: begin
        if (rxValid) begin
          if (rxData[DW-1:4] != '0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            fun_d   = rxData[3:0];
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        err_d   = rxValid;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        err_d = rxValid;
        if (aluOutValid) begin
          res_d   = aluOut;
          state_d = S_TX_LO;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TX_LO: begin
        err_d = rxValid;
        if (txReady) state_d = S_TX_HI;
      end
      S_TX_HI: begin
        err_d = rxValid;
        if (txReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      fun_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      fun_q   <= fun_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign opA     = opa_q;
  assign opB     = opb_q;
  assign aluFun  = fun_q;
  assign aluEn   = (state_q == S_RUN);
  assign txValid = (state_q == S_TX_LO) || (state_q == S_TX_HI);
  assign txData  = (state_q == S_TX_HI) ? res_q[2*DW-1:DW] :
                   (state_q == S_TX_LO) ? res_q[DW-1:0] : '0;
  assign busy    = (state_q != S_IDLE);
  assign cmdErr  = err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl.
// Directed frames plus random frames against a frame-level model.
module tb_alu_cmd_ctrl;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  rxData;
  logic        rxValid;
  logic [15:0] aluOut;
  logic        aluOutValid;
  logic        txReady;
  logic [7:0]  opA;
  logic [7:0]  opB;
  logic [3:0]  aluFun;
  logic        aluEn;
  logic [7:0]  txData;
  logic        txValid;
  logic        busy;
  logic        cmdErr;

  alu_cmd_ctrl dut (
    .clk(clk),
    .rst(rst),
    .rxData(rxData),
    .rxValid(rxValid),
    .aluOut(aluOut),
    .aluOutValid(aluOutValid),
    .txReady(txReady),
    .opA(opA),
    .opB(opB),
    .aluFun(aluFun),
    .aluEn(aluEn),
    .txData(txData),
    .txValid(txValid),
    .busy(busy),
    .cmdErr(cmdErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int en_cnt = 0;
  int err_cnt = 0;
  int txv_cnt = 0;
  logic [7:0] got[$];

  logic [7:0] exp_a = 8'h00;
  logic [7:0] exp_b = 8'h00;
  logic [3:0] exp_fun = 4'h0;

  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Passive observer: event counts, accepted TX bytes, hold-under-stall
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("tx_hold_valid", txValid, 1);
        chk("tx_hold_data", txData, pd);
      end
      if (aluEn) en_cnt++;
      if (cmdErr) err_cnt++;
      if (txValid) txv_cnt++;
      if (txValid && txReady) got.push_back(txData);
      pv = txValid;
      pr = txReady;
      pd = txData;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxValid = 1'b1;
    rxData = b;
    step();
    rxValid = 1'b0;
  endtask

  task automatic recv(input int sl, input int sh, input logic [15:0] resp);
    chk("tx_latency", txValid, 1);
    txReady = 1'b0;
    repeat (sl) step();
    txReady = 1'b1;
    step();
    txReady = 1'b0;
    chk("tx_hi_valid", txValid, 1);
    repeat (sh) step();
    txReady = 1'b1;
    step();
    txReady = 1'b0;
    chk("tx_done", txValid, 0);
    chk("tx_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("tx_lo_byte", got[0], resp[7:0]);
      chk("tx_hi_byte", got[1], resp[15:8]);
    end
    got.delete();
  endtask

  task automatic do_op(input bit full, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] f,
                       input int lat, input logic [15:0] resp,
                       input int sl, input int sh, input bit rxw);
    int e0;
    int n0;
    int v0;
    int lim;
    e0 = err_cnt;
    n0 = en_cnt;
    v0 = txv_cnt;
    if (full) begin
      send_byte(8'hCC);
      send_byte(a);
      send_byte(b);
      exp_a = a;
      exp_b = b;
    end else begin
      send_byte(8'hDD);
    end
    send_byte(f);
    if (f[7:4] != 4'h0) begin
      chk("badfun_err", cmdErr, 1);
      chk("badfun_idle", busy, 0);
      chk("badfun_noen", aluEn, 0);
      chk("badfun_opa", opA, exp_a);
      chk("badfun_opb", opB, exp_b);
      chk("badfun_fun", aluFun, exp_fun);
      step();
      chk("badfun_errcnt", err_cnt - e0, 1);
      chk("badfun_encnt", en_cnt - n0, 0);
      return;
    end
    exp_fun = f[3:0];
    chk("run_en", aluEn, 1);
    chk("run_opa", opA, exp_a);
    chk("run_opb", opB, exp_b);
    chk("run_fun", aluFun, exp_fun);
    chk("run_busy", busy, 1);
    step();
    lim = (lat > 0) ? lat : TO;
    for (int k = 1; k <= lim; k++) begin
      aluOutValid = (k == lat);
      aluOut = (k == lat) ? resp : 16'($urandom);
      rxValid = rxw && (k == 1);
      rxData = 8'h5A;
      step();
      aluOutValid = 1'b0;
      rxValid = 1'b0;
      if (lat == 0 && k == TO - 1) chk("to_early", busy, 1);
      if (lat == 0 && k == TO) begin
        chk("to_err", cmdErr, 1);
        chk("to_idle", busy, 0);
      end
    end
    if (lat > 0) begin
      recv(sl, sh, resp);
    end else begin
      repeat (3) step();
      chk("to_notx", txv_cnt - v0, 0);
    end
    chk("err_count", err_cnt - e0, int'(lat == 0) + int'(rxw));
    chk("en_count", en_cnt - n0, 1);
    chk("end_idle", busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_opA"}, opA, 0);
    chk({tag, "_opB"}, opB, 0);
    chk({tag, "_fun"}, aluFun, 0);
    chk({tag, "_en"}, aluEn, 0);
    chk({tag, "_txd"}, txData, 0);
    chk({tag, "_txv"}, txValid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, cmdErr, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst = 1'b1;
    rxData = 8'h00;
    rxValid = 1'b0;
    aluOut = 16'h0000;
    aluOutValid = 1'b0;
    txReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    step();

    do_op(0, 8'h00, 8'h00, 8'h03, 2, 16'h1234, 0, 0, 0);
    do_op(1, 8'h12, 8'h34, 8'h00, 2, 16'h0046, 0, 0, 0);
    do_op(0, 8'h00, 8'h00, 8'h05, 2, 16'hABCD, 0, 0, 0);
    do_op(1, 8'h9C, 8'h3E, 8'h0A, 3, 16'h5AA5, 5, 3, 0);

    e0 = err_cnt;
    send_byte(8'h55);
    chk("badop_err", cmdErr, 1);
    chk("badop_busy", busy, 0);
    step();
    chk("badop_pulse", cmdErr, 0);
    chk("badop_count", err_cnt - e0, 1);

    do_op(1, 8'h77, 8'h88, 8'h1F, 0, 16'h0000, 0, 0, 0);
    do_op(1, 8'h21, 8'h43, 8'h06, 3, 16'hC0DE, 1, 1, 1);
    do_op(1, 8'h0F, 8'hF0, 8'h09, 0, 16'h0000, 0, 0, 0);
    do_op(0, 8'h00, 8'h00, 8'h0C, TO, 16'h8001, 0, 2, 0);
    do_op(0, 8'h00, 8'h00, 8'h0D, 1, 16'h7E81, 2, 0, 1);

    send_byte(8'hCC);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h01);
    step();
    aluOutValid = 1'b1;
    aluOut = 16'hBEEF;
    step();
    aluOutValid = 1'b0;
    txReady = 1'b1;
    step();
    txReady = 1'b0;
    chk("pre_rst_txv", txValid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
    exp_a = 8'h00;
    exp_b = 8'h00;
    exp_fun = 4'h0;
    step();
    do_op(1, 8'h01, 8'h01, 8'h00, 2, 16'h0002, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      do_op(bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            {4'h0, 4'($urandom)}, $urandom_range(1, TO),
            16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
